// File: rtl/inertial_fusion_cal.sv
// ---------------------------------------------------------------------------
// inertial_fusion_cal
//
// Pitch estimator for the Segway balance path. The block integrates the
// bias-corrected gyro pitch rate into a saturating accumulator. On every
// sample it also nudges that accumulator by a fixed step toward a pitch
// estimate derived from the accelerometer, which cancels long-term gyro drift.
//
// A small calibration FSM measures the gyro bias at run time. It averages
// 2^CAL_LOG2 gyro samples and uses the result in place of the fixed
// reset-time offset.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   vld        single-cycle strobe: new sample on ptch_rt / AZ
//   ptch_rt    signed gyro pitch rate
//   AZ         signed accelerometer Z
//   cal_req    recalibration request (level, sampled every cycle)
//   ptch       signed fused pitch (top DW bits of the integrator)
//   ptch_vld   one-cycle pulse after ptch updates in RUN
//   cal_busy   high while calibrating
//   cal_done   one-cycle pulse after calibration completes
//   gyro_bias  current gyro bias estimate
// ---------------------------------------------------------------------------
module inertial_fusion_cal #(
  parameter int            DW              = 16,
  parameter int            INT_W           = 27,
  parameter logic [DW-1:0] AZ_OFFSET       = 16'h00A0,
  parameter int            ACC_SCALE       = 327,
  parameter int            ACC_SHIFT       = 13,
  parameter int            FUSION_STEP     = 1024,
  parameter logic [DW-1:0] GYRO_OFFSET_RST = 16'h0050,
  parameter int            CAL_LOG2        = 4,
  parameter bit            CAL_ON_RST      = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld,
  input  logic [DW-1:0] ptch_rt,
  input  logic [DW-1:0] AZ,
  input  logic          cal_req,
  output logic [DW-1:0] ptch,
  output logic          ptch_vld,
  output logic          cal_busy,
  output logic          cal_done,
  output logic [DW-1:0] gyro_bias
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_CAL = 1'b1;

  // ACC_SCALE is at most 10 bits unsigned, so it is held as an 11-bit
  // signed value. The product then needs (DW+1) + 11 bits.
  localparam int                    PW      = DW + 12;
  localparam logic signed [10:0]    SCALE_S = 11'(ACC_SCALE);

  // The integrator update is done at INT_W+2 bits, so the sum of the old
  // integrator, the rate and the fusion step cannot overflow before the
  // result is clamped.
  localparam int                    NW      = INT_W + 2;
  localparam logic signed [NW-1:0]  STEP_P  = NW'(FUSION_STEP);
  localparam logic signed [NW-1:0]  STEP_N  = -STEP_P;
  localparam logic signed [NW-1:0]  INT_MAX = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [NW-1:0]  INT_MIN = {3'b111, {(INT_W-1){1'b0}}};

  localparam int                    CW      = DW + CAL_LOG2;

  logic [0:0]                state;
  logic signed [INT_W-1:0]   ptch_int;
  logic signed [DW-1:0]      ptch_acc;
  logic signed [CW-1:0]      cal_sum;
  logic [CAL_LOG2-1:0]       cal_cnt;

  logic signed [DW-1:0]      rt_s;
  logic signed [DW-1:0]      az_s;
  logic signed [DW-1:0]      bias_s;
  logic signed [DW-1:0]      ptch_s;
  logic signed [DW:0]        az_c;
  logic signed [DW:0]        rate_c;
  logic signed [PW-1:0]      acc_prod;
  logic signed [DW-1:0]      acc_nxt;
  logic signed [NW-1:0]      fusion_term;
  logic signed [NW-1:0]      int_nxt;
  logic signed [INT_W-1:0]   int_sat;
  logic signed [CW-1:0]      cal_add;
  logic [DW-1:0]             cal_avg;
  logic                      cal_last;

  assign rt_s     = ptch_rt;
  assign az_s     = AZ;
  assign bias_s   = gyro_bias;
  assign ptch_s   = ptch_int[INT_W-1 -: DW];
  assign ptch     = ptch_s;
  assign cal_busy = (state == ST_CAL);

  // Accelerometer pitch. Both differences are formed one bit wider than
  // the inputs, so a full-scale input minus the offset cannot wrap.
  assign az_c     = (DW+1)'(az_s) - $signed({1'b0, AZ_OFFSET});
  assign acc_prod = PW'(az_c) * PW'(SCALE_S);
  assign acc_nxt  = DW'(acc_prod >>> ACC_SHIFT);

  // Gyro rate with the current bias estimate removed.
  assign rate_c   = (DW+1)'(rt_s) - (DW+1)'(bias_s);

  // Fusion step toward the accelerometer. Equal values give no correction.
  // This deadband keeps ptch from dithering by one LSB around the target.
  always_comb begin
    fusion_term = '0;
    if (ptch_acc > ptch_s) begin
      fusion_term = STEP_P;
    end else if (ptch_acc < ptch_s) begin
      fusion_term = STEP_N;
    end
  end

  // Next integrator value, clamped so a long run in one direction holds at
  // full scale rather than wrapping to the opposite sign.
  always_comb begin
    int_nxt = NW'(ptch_int) - NW'(rate_c) + fusion_term;
    int_sat = INT_W'(int_nxt);
    if (int_nxt > INT_MAX) begin
      int_sat = INT_W'(INT_MAX);
    end else if (int_nxt < INT_MIN) begin
      int_sat = INT_W'(INT_MIN);
    end
  end

  // Calibration accumulator. The final sample is folded in on the same edge
  // that computes the average, so no extra cycle is spent.
  assign cal_add  = cal_sum + CW'(rt_s);
  assign cal_avg  = DW'(cal_add >>> CAL_LOG2);
  assign cal_last = &cal_cnt;

  // Main sequential block. The accelerometer pitch tracks every sample in
  // either state. The integrator runs only in RUN. A cal_req in RUN takes
  // priority over a simultaneous sample, and that sample is dropped from
  // the integrator. cal_req is ignored once calibration has started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CAL_ON_RST ? ST_CAL : ST_RUN;
      ptch_int  <= '0;
      ptch_acc  <= '0;
      ptch_vld  <= 1'b0;
      cal_done  <= 1'b0;
      gyro_bias <= GYRO_OFFSET_RST;
      cal_sum   <= '0;
      cal_cnt   <= '0;
    end else begin
      ptch_vld <= 1'b0;
      cal_done <= 1'b0;
      if (vld) begin
        ptch_acc <= acc_nxt;
      end
      case (state)
        ST_RUN: begin
          if (cal_req) begin
            state    <= ST_CAL;
            ptch_int <= '0;
            cal_sum  <= '0;
            cal_cnt  <= '0;
          end else if (vld) begin
            ptch_int <= int_sat;
            ptch_vld <= 1'b1;
          end
        end
        ST_CAL: begin
          if (vld) begin
            if (cal_last) begin
              gyro_bias <= cal_avg;
              state     <= ST_RUN;
              cal_done  <= 1'b1;
              cal_sum   <= '0;
              cal_cnt   <= '0;
            end else begin
              cal_sum <= cal_add;
              cal_cnt <= cal_cnt + CAL_LOG2'(1);
            end
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inertial_fusion_cal.sv
// ---------------------------------------------------------------------------
// tb_inertial_fusion_cal
//
// Self-checking bench for inertial_fusion_cal with the default parameters.
// A behavioural model is stepped alongside every driven cycle. Each RUN
// sample pushes its expected ptch into a scoreboard queue, and the entry is
// popped when the DUT raises ptch_vld. Hand-computed vector tables and
// explicit checks cover the multi-cycle corner cases: calibration, sample
// lag, saturation, the cal_req/vld collision and reset during calibration.
// ---------------------------------------------------------------------------
module tb_inertial_fusion_cal;

  localparam longint SAT_MAX = 64'sd67108863;
  localparam longint SAT_MIN = -64'sd67108864;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        cal_req = 1'b0;
  logic [15:0] ptch_rt = '0;
  logic [15:0] AZ = '0;
  logic [15:0] ptch;
  logic        ptch_vld;
  logic        cal_busy;
  logic        cal_done;
  logic [15:0] gyro_bias;

  always #5 clk = ~clk;

  inertial_fusion_cal #(
    .DW(16), .INT_W(27), .AZ_OFFSET(16'h00A0), .ACC_SCALE(327),
    .ACC_SHIFT(13), .FUSION_STEP(1024), .GYRO_OFFSET_RST(16'h0050),
    .CAL_LOG2(4), .CAL_ON_RST(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ),
    .cal_req(cal_req), .ptch(ptch), .ptch_vld(ptch_vld),
    .cal_busy(cal_busy), .cal_done(cal_done), .gyro_bias(gyro_bias)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int vld_seen = 0;
  int sat_neg = 0;
  bit in_sat = 1'b0;

  // Model state
  longint      m_int, m_acc, m_bias, m_sum;
  int          m_cnt;
  bit          m_cal, exp_vld, exp_done;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [15:0] rt;
    logic [15:0] az;
    logic [15:0] exp_ptch;
  } vec_t;

  vec_t tbl[8];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic resetModel();
    m_int = 0; m_acc = 0; m_bias = 80; m_sum = 0; m_cnt = 0;
    m_cal = 1'b1; exp_vld = 1'b0; exp_done = 1'b0;
    sb_q.delete();
  endtask

  task automatic modelStep(input logic v, input logic [15:0] rt, input logic [15:0] az,
                           input logic req);
    longint rt_l, az_l, p_old, fus, nxt, tmp, prod;
    logic [15:0] t16;
    rt_l = longint'($signed(rt));
    az_l = longint'($signed(az));
    exp_vld = 1'b0;
    exp_done = 1'b0;
    p_old = m_int >>> 11;
    if (m_acc > p_old) fus = 1024;
    else if (m_acc < p_old) fus = -1024;
    else fus = 0;
    if (!m_cal) begin
      if (req) begin
        m_int = 0; m_sum = 0; m_cnt = 0; m_cal = 1'b1;
      end else if (v) begin
        nxt = m_int - (rt_l - m_bias) + fus;
        if (nxt > SAT_MAX) nxt = SAT_MAX;
        else if (nxt < SAT_MIN) nxt = SAT_MIN;
        m_int = nxt;
        exp_vld = 1'b1;
        tmp = nxt >>> 11;
        t16 = tmp[15:0];
        sb_q.push_back(t16);
      end
    end else if (v) begin
      if (m_cnt == 15) begin
        tmp = (m_sum + rt_l) >>> 4;
        t16 = tmp[15:0];
        m_bias = longint'($signed(t16));
        m_cal = 1'b0; m_sum = 0; m_cnt = 0;
        exp_done = 1'b1;
      end else begin
        m_sum = m_sum + rt_l;
        m_cnt++;
      end
    end
    if (v) begin
      prod = (az_l - 160) * 327;
      tmp = prod >>> 13;
      t16 = tmp[15:0];
      m_acc = longint'($signed(t16));
    end
  endtask

  // Per-cycle comparison against the model, plus the scoreboard pop
  task automatic compareCycle();
    longint tmp;
    logic [15:0] mp, mb, exp_p;
    tmp = m_int >>> 11;
    mp = tmp[15:0];
    mb = m_bias[15:0];
    checkOutput("ptch", ptch, mp);
    checkOutput("cal_busy", cal_busy, m_cal);
    checkOutput("gyro_bias", gyro_bias, mb);
    checkOutput("cal_done", cal_done, exp_done);
    checkOutput("ptch_vld", ptch_vld, exp_vld);
    if (ptch_vld) begin
      vld_seen++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL sb_underflow: got ptch_vld with empty queue, expected none");
      end else begin
        exp_p = sb_q.pop_front();
        checkOutput("sb_ptch", ptch, exp_p);
      end
    end
    if (in_sat && ptch[15]) sat_neg++;
  endtask

  // Drive one cycle from a negedge, check after the rising edge, and
  // return at the following negedge
  task automatic applyStimulus(input logic v, input logic [15:0] rt, input logic [15:0] az,
                               input logic req);
    vld = v; ptch_rt = rt; AZ = az; cal_req = req;
    modelStep(v, rt, az, req);
    @(posedge clk);
    #1;
    compareCycle();
    @(negedge clk);
    vld = 1'b0; cal_req = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'hF858, 16'h00A0, 16'h0001};
    tbl[1] = '{16'h0058, 16'h00A0, 16'h0000};
    tbl[2] = '{16'h0058, 16'h00A0, 16'h0000};
    tbl[3] = '{16'h1058, 16'h00A0, 16'hFFFE};
    tbl[4] = '{16'h0058, 16'h00A0, 16'hFFFF};
    tbl[5] = '{16'h0058, 16'h00A0, 16'hFFFF};
    tbl[6] = '{16'h0058, 16'h00A0, 16'h0000};
    tbl[7] = '{16'h0058, 16'h00A0, 16'h0000};

    resetModel();
    #12;
    checkOutput("rst_ptch", ptch, 0);
    checkOutput("rst_ptch_vld", ptch_vld, 0);
    checkOutput("rst_cal_done", cal_done, 0);
    checkOutput("rst_gyro_bias", gyro_bias, 16'h0050);
    checkOutput("rst_cal_busy", cal_busy, 1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] calibrate from reset");
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 16'h0058, 16'h00A0, 1'b0);
    checkOutput("cal1_no_early_done", cal_done, 0);
    applyStimulus(1'b1, 16'h0058, 16'h00A0, 1'b0);
    checkOutput("cal1_done", cal_done, 1);
    checkOutput("cal1_busy_low", cal_busy, 0);
    checkOutput("cal1_bias", gyro_bias, 16'h0058);
    applyStimulus(1'b0, 16'h0058, 16'h00A0, 1'b0);
    checkOutput("cal1_done_single", cal_done, 0);

    $display("[TB] steady state");
    vld_seen = 0;
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 16'h0058, 16'h00A0, 1'b0);
    checkOutput("steady_vld_count", vld_seen, 100);
    checkOutput("steady_ptch", ptch, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, tbl[i].rt, tbl[i].az, 1'b0);
      checkOutput("table_ptch", ptch, tbl[i].exp_ptch);
    end

    $display("[TB] recalibration collision");
    for (int k = 1; k <= 401; k++) applyStimulus(1'b1, 16'h0058, 16'h20A0, 1'b0);
    checkOutput("coll_pre_ptch", ptch, 200);
    applyStimulus(1'b1, 16'h0058, 16'h20A0, 1'b1);
    checkOutput("coll_ptch_zero", ptch, 0);
    checkOutput("coll_busy", cal_busy, 1);
    checkOutput("coll_no_vld", ptch_vld, 0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 16'h0058, 16'h00A0, (i == 5));
    checkOutput("coll_no_early_done", cal_done, 0);
    checkOutput("coll_still_busy", cal_busy, 1);
    applyStimulus(1'b1, 16'h0058, 16'h00A0, 1'b0);
    checkOutput("coll_done", cal_done, 1);
    checkOutput("coll_bias", gyro_bias, 16'h0058);

    $display("[TB] accelerometer convergence");
    for (int k = 1; k <= 675; k++) begin
      applyStimulus(1'b1, 16'h0058, 16'h20A0, 1'b0);
      if (k == 1) checkOutput("conv_lag", ptch, 0);
      if (k == 654) checkOutput("conv_654", ptch, 326);
      if (k == 655) checkOutput("conv_655", ptch, 327);
    end
    checkOutput("conv_hold", ptch, 327);

    $display("[TB] saturation");
    applyStimulus(1'b0, 16'h0000, 16'h00A0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'h0000, 16'h00A0, 1'b0);
    checkOutput("sat_bias_zero", gyro_bias, 0);
    in_sat = 1'b1;
    for (int i = 0; i < 3000; i++) applyStimulus(1'b1, 16'h8000, 16'h7FFF, 1'b0);
    in_sat = 1'b0;
    checkOutput("sat_ptch", ptch, 16'h7FFF);
    checkOutput("sat_never_neg", sat_neg, 0);

    $display("[TB] reset mid-calibration");
    applyStimulus(1'b0, 16'h0058, 16'h00A0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'h0058, 16'h00A0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_ptch", ptch, 0);
    checkOutput("arst_bias", gyro_bias, 16'h0050);
    checkOutput("arst_busy", cal_busy, 1);
    checkOutput("arst_done", cal_done, 0);
    checkOutput("arst_vld", ptch_vld, 0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 16'h0060, 16'h00A0, 1'b0);
    checkOutput("arst_no_early_done", cal_done, 0);
    checkOutput("arst_busy_15", cal_busy, 1);
    applyStimulus(1'b1, 16'h0060, 16'h00A0, 1'b0);
    checkOutput("arst_cal_done", cal_done, 1);
    checkOutput("arst_new_bias", gyro_bias, 16'h0060);
    checkOutput("arst_busy_low", cal_busy, 0);

    checkOutput("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inertial_fusion_cal.md
Name: inertial_fusion_cal

Overview:
- Parametrised pitch estimator for the Segway balance path. Integrates bias-corrected gyro pitch rate into a saturating accumulator.
- Each sample, nudges the accumulator by a fixed step toward an accelerometer-derived pitch to cancel drift.
- Adds a run-time gyro-bias calibration FSM that averages 2^CAL_LOG2 samples, replacing the fixed gyro offset.
- Sits between the inertial sensor interface and the balance controller.

Parameters:
- DW, 16: width of ptch_rt, AZ, ptch, gyro_bias (signed).
- INT_W, 27: integrator width (signed); ptch = ptch_int[INT_W-1 -: DW].
- AZ_OFFSET, 16'h00A0: accelerometer Z bias subtracted from AZ.
- ACC_SCALE, 327: AZ-to-pitch multiplier; unsigned, at most 10 bits.
- ACC_SHIFT, 13: arithmetic right shift applied to the AZ product.
- FUSION_STEP, 1024: per-sample correction magnitude added to the integrator.
- GYRO_OFFSET_RST, 16'h0050: gyro_bias value loaded at reset.
- CAL_LOG2, 4: calibration averages 2^CAL_LOG2 samples.
- CAL_ON_RST, 1: 1 = enter CAL after reset; 0 = enter RUN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vld  in  1  single-cycle strobe, new sample on ptch_rt/AZ
- ptch_rt  in  DW  signed gyro pitch rate
- AZ  in  DW  signed accelerometer Z
- cal_req  in  1  request recalibration (level sampled each cycle)
- ptch  out  DW  signed fused pitch
- ptch_vld  out  1  one-cycle pulse when ptch has updated in RUN
- cal_busy  out  1  high while in CAL
- cal_done  out  1  one-cycle pulse when calibration completes
- gyro_bias  out  DW  current gyro bias estimate

Behaviour:
- Reset is asynchronous and active-low, on rst_n; clock is clk. All flops use it.
- Reset values:
  - ptch_int = 0, ptch_acc = 0, ptch = 0, ptch_vld = 0, cal_done = 0.
  - gyro_bias = GYRO_OFFSET_RST, cal_sum = 0, cal_cnt = 0.
  - State = CAL if CAL_ON_RST = 1, else RUN; cal_busy follows state (1 in CAL).
- Reset mid-operation aborts everything and restores the reset values.
- Accelerometer path:
  - Update on vld only, in any state.
  - az_c = AZ - AZ_OFFSET, computed at DW+1 bits.
  - ptch_acc <= (az_c * ACC_SCALE) >>> ACC_SHIFT, truncated to DW.
- Fusion term, using pre-edge registered values:
  - +FUSION_STEP if ptch_acc > ptch.
  - -FUSION_STEP if ptch_acc < ptch.
  - 0 if equal (deadband, no dither).
- Because ptch_acc is registered, fusion lags the accelerometer by one sample.
- RUN on vld:
  - rate_c = ptch_rt - gyro_bias, at DW+1 bits.
  - nxt = ptch_int - rate_c + fusion, computed at INT_W+2 bits.
  - ptch_int <= nxt, saturated to [-2^(INT_W-1), 2^(INT_W-1)-1]; it never wraps.
  - ptch_vld = 1 in the cycle after the updating edge.
- RUN, no vld: ptch_int holds.
- FSM:
  - RUN -> CAL when cal_req = 1. On that edge: ptch_int <= 0, cal_sum <= 0, cal_cnt <= 0, no ptch_vld.
  - If vld is high on the same cycle as cal_req, cal_req wins and the sample is discarded from the integrator; ptch_acc still updates.
  - CAL on vld: cal_sum += sign-extended ptch_rt (DW+CAL_LOG2 bits); cal_cnt += 1.
  - On the vld where cal_cnt = 2^CAL_LOG2-1: gyro_bias <= (cal_sum + ptch_rt) >>> CAL_LOG2, state <= RUN.
  - cal_done pulses one cycle after that edge; cal_busy drops on the same edge.
  - cal_req during CAL is ignored; calibration is not restarted.
  - ptch_int stays 0 throughout CAL; ptch_vld stays 0.
- The first RUN sample after CAL uses the new gyro_bias.

Test Plan:
- Calibrate from reset:
  - Stimulus: CAL_ON_RST = 1; 16 vld with ptch_rt = 16'h0058, AZ = 16'h00A0.
  - Response: gyro_bias = 16'h0058; cal_done pulses once, one cycle after the 16th vld; cal_busy low afterwards; ptch = 0 throughout.
- Steady state after calibration:
  - Stimulus: RUN with ptch_rt = 16'h0058, AZ = 16'h00A0, 100 vld.
  - Response: ptch_acc = 0, fusion = 0, ptch stays 0; ptch_vld pulses 100 times.
- Accelerometer convergence:
  - Stimulus: RUN with ptch_rt = gyro_bias, AZ = 16'h20A0 (az_c = 8192, so ptch_acc = 327).
  - Response: first vld gives no change (lag); each later vld adds 1024 to ptch_int; ptch = 327 after vld 655 and stays exactly 327.
- Saturation:
  - Stimulus: gyro_bias = 0, ptch_rt = -32768, AZ = 16'h7FFF, 3000 vld.
  - Response: ptch_int clamps at 2^26-1; ptch = 16'h7FFF; it never goes negative.
- Recalibration collision:
  - Stimulus: cal_req and vld high on the same cycle while ptch = 200.
  - Response: next cycle ptch = 0, cal_busy = 1, no ptch_vld; a cal_req pulse mid-CAL still gives exactly 16 vld to cal_done.
- Reset mid-CAL:
  - Stimulus: assert rst_n low asynchronously after 7 calibration samples.
  - Response: ptch = 0, gyro_bias = 16'h0050, cal_busy = 1 immediately; a full 16 samples are needed after release.
